frame_transmitter: RTL and testbench

Parametrised serial frame transmitter, successor to the single-byte SFD+data serialiser. Sends a start-of-frame delimiter, then a variable-length payload of DATA_W-bit words pulled over a valid/ready stream, LSB first. Bit period is programmable, and a mandatory inter-frame gap follows each frame. Sits between the packet source and the line driver.

---
 rtl/tx_pkg.sv | 23 ++
 rtl/bit_timer.sv | 28 ++
 rtl/frame_transmitter.sv | 220 ++++++++++++++++++++++
 tb/tb_frame_transmitter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared definitions for the serial frame transmitter and its receiver counterpart:
// state encoding, default delimiter and the CRC-8 polynomial with its bit-serial step.
package tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SFD,
        ST_DATA,
        ST_CRC,
        ST_GAP
    } tx_state_t;

    localparam logic [7:0] SFD_DEFAULT = 8'hD5;
    localparam logic [7:0] CRC8_POLY   = 8'h07;

    // One bit of CRC-8 (x^8+x^2+x+1), bits fed in line order
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period prescaler: bit_tick is high in the last clock of every CLKS_PER_BIT-clock period
// while run is high; the period restarts whenever run is low.
module bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic bit_tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt;

    assign bit_tick = run && (cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!run || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/frame_transmitter.sv
// Serial frame transmitter: SFD, then tr_len payload words pulled over valid/ready, LSB first,
// then an inter-frame gap. Define TX_CRC8_EN to append a CRC-8 (MSB first) after the payload.
module frame_transmitter
    import tx_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned MAX_WORDS    = 16,
    parameter int unsigned SFD_LEN      = 8,
    parameter logic [SFD_LEN-1:0] SFD   = SFD_LEN'(SFD_DEFAULT),
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned IFG_BITS     = 4,
    parameter int unsigned LEN_W        = $clog2(MAX_WORDS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tr_start,
    input  logic [LEN_W-1:0]  tr_len,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              tx,
    output logic              tx_en,
    output logic              tr_free,
    output logic              tr_done,
    output logic              tr_err
);

    localparam int unsigned MAX_A = (SFD_LEN > DATA_W) ? SFD_LEN : DATA_W;
    localparam int unsigned MAX_B = (MAX_A > IFG_BITS) ? MAX_A : IFG_BITS;
    localparam int unsigned MAX_C = (MAX_B > 8) ? MAX_B : 8;
    localparam int unsigned CNT_W = $clog2(MAX_C);

    tx_state_t         state, state_n;
    logic              tx_n, tx_en_n, tr_free_n, tr_done_n, tr_err_n;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [LEN_W-1:0]  words_left, words_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [SFD_LEN-1:0] sfd_sh;
    logic              bit_tick;
    logic              len_ok;
    logic              sfd_last, data_last, last_word;
`ifdef TX_CRC8_EN
    logic [7:0]        crc, crc_n, crc_upd;
`endif

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .run     (state != ST_IDLE),
        .bit_tick(bit_tick)
    );

    assign len_ok    = (tr_len != '0) && (tr_len <= LEN_W'(MAX_WORDS));
    assign sfd_last  = (bit_cnt == CNT_W'(SFD_LEN - 1));
    assign data_last = (bit_cnt == CNT_W'(DATA_W - 1));
    assign last_word = (words_left == LEN_W'(1));

    // Load point: final clock of the SFD or of a payload word that is not the last one
    assign din_ready = bit_tick &&
                       (((state == ST_SFD) && sfd_last) ||
                        ((state == ST_DATA) && data_last && !last_word));

    // Next-state and next-output logic
    always_comb begin
        state_n   = state;
        tx_n      = tx;
        tx_en_n   = tx_en;
        tr_free_n = tr_free;
        tr_done_n = 1'b0;
        tr_err_n  = 1'b0;
        bit_cnt_n = bit_cnt;
        words_n   = words_left;
        shreg_n   = shreg;
        sfd_sh    = SFD >> (bit_cnt + CNT_W'(1));
`ifdef TX_CRC8_EN
        crc_n     = crc;
        crc_upd   = crc8_step(crc, tx);
`endif

        case (state)
            ST_IDLE: begin
                if (tr_start) begin
                    if (len_ok) begin
                        state_n   = ST_SFD;
                        tx_n      = SFD[0];
                        tx_en_n   = 1'b1;
                        tr_free_n = 1'b0;
                        bit_cnt_n = '0;
                        words_n   = tr_len;
`ifdef TX_CRC8_EN
                        crc_n     = 8'h00;
`endif
                    end else begin
                        tr_err_n = 1'b1;
                    end
                end
            end
            ST_SFD: begin
                if (bit_tick && !sfd_last) begin
                    tx_n      = sfd_sh[0];
                    bit_cnt_n = bit_cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
`ifdef TX_CRC8_EN
                    crc_n = crc_upd;
`endif
                    if (!data_last) begin
                        shreg_n   = shreg >> 1;
                        tx_n      = shreg[1];
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                    end else if (last_word) begin
                        bit_cnt_n = '0;
`ifdef TX_CRC8_EN
                        state_n   = ST_CRC;
                        tx_n      = crc_upd[7];
`else
                        state_n   = ST_GAP;
                        tx_n      = 1'b0;
                        tx_en_n   = 1'b0;
                        tr_done_n = 1'b1;
`endif
                    end else begin
                        words_n = words_left - LEN_W'(1);
                    end
                end
            end
`ifdef TX_CRC8_EN
            ST_CRC: begin
                if (bit_tick) begin
                    if (bit_cnt == CNT_W'(7)) begin
                        state_n   = ST_GAP;
                        tx_n      = 1'b0;
                        tx_en_n   = 1'b0;
                        tr_done_n = 1'b1;
                        bit_cnt_n = '0;
                    end else begin
                        crc_n     = {crc[6:0], 1'b0};
                        tx_n      = crc[6];
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                    end
                end
            end
`endif
            ST_GAP: begin
                tx_n    = 1'b0;
                tx_en_n = 1'b0;
                if (bit_tick) begin
                    if (bit_cnt == CNT_W'(IFG_BITS - 1)) begin
                        state_n   = ST_IDLE;
                        tr_free_n = 1'b1;
                        bit_cnt_n = '0;
                    end else begin
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_n   = ST_IDLE;
                tx_n      = 1'b0;
                tx_en_n   = 1'b0;
                tr_free_n = 1'b1;
                bit_cnt_n = '0;
            end
        endcase

        // Word handover: capture the next word, or abort the frame on underrun
        if (din_ready) begin
            bit_cnt_n = '0;
            if (din_valid) begin
                state_n = ST_DATA;
                shreg_n = din;
                tx_n    = din[0];
            end else begin
                state_n  = ST_GAP;
                tx_n     = 1'b0;
                tx_en_n  = 1'b0;
                tr_err_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            tx         <= 1'b0;
            tx_en      <= 1'b0;
            tr_free    <= 1'b1;
            tr_done    <= 1'b0;
            tr_err     <= 1'b0;
            bit_cnt    <= '0;
            words_left <= '0;
            shreg      <= '0;
        end else begin
            state      <= state_n;
            tx         <= tx_n;
            tx_en      <= tx_en_n;
            tr_free    <= tr_free_n;
            tr_done    <= tr_done_n;
            tr_err     <= tr_err_n;
            bit_cnt    <= bit_cnt_n;
            words_left <= words_n;
            shreg      <= shreg_n;
        end
    end

`ifdef TX_CRC8_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc <= 8'h00;
        end else begin
            crc <= crc_n;
        end
    end
`endif

endmodule

// File: tb/tb_frame_transmitter.sv
// Scoreboard bench for frame_transmitter: one instance at 1 clock/bit, one at 4 clocks/bit.
// Expected line bits are queued per frame and popped by a monitor while tx_en is high.
module tb_frame_transmitter;

    localparam int unsigned LEN_W = 5;
`ifdef TX_CRC8_EN
    localparam int CRC_BITS = 8;
`else
    localparam int CRC_BITS = 0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             tr_start;
    logic [LEN_W-1:0] tr_len;
    logic [7:0]       din;
    logic             din_valid;
    logic             sel;

    logic d1_ready, d1_tx, d1_en, d1_free, d1_done, d1_err;
    logic d4_ready, d4_tx, d4_en, d4_free, d4_done, d4_err;
    logic s_ready, s_tx, s_en, s_free, s_done, s_err;

    always #5 clk = ~clk;

    frame_transmitter #(.CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .reset(reset), .tr_start(tr_start & ~sel), .tr_len(tr_len),
        .din(din), .din_valid(din_valid), .din_ready(d1_ready), .tx(d1_tx),
        .tx_en(d1_en), .tr_free(d1_free), .tr_done(d1_done), .tr_err(d1_err)
    );

    frame_transmitter #(.CLKS_PER_BIT(4)) u_dut4 (
        .clk(clk), .reset(reset), .tr_start(tr_start & sel), .tr_len(tr_len),
        .din(din), .din_valid(din_valid), .din_ready(d4_ready), .tx(d4_tx),
        .tx_en(d4_en), .tr_free(d4_free), .tr_done(d4_done), .tr_err(d4_err)
    );

    assign s_ready = sel ? d4_ready : d1_ready;
    assign s_tx    = sel ? d4_tx    : d1_tx;
    assign s_en    = sel ? d4_en    : d1_en;
    assign s_free  = sel ? d4_free  : d1_free;
    assign s_done  = sel ? d4_done  : d1_done;
    assign s_err   = sel ? d4_err   : d1_err;

    int checks = 0;
    int errors = 0;
    int cpb    = 1;
    bit         exp_q[$];
    logic [7:0] feed_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic refresh_din();
        din_valid = (feed_q.size() > 0);
        din       = (feed_q.size() > 0) ? feed_q[0] : 8'h00;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit msb_first);
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < cpb; k++)
                exp_q.push_back(msb_first ? b[7-i] : b[i]);
    endtask

    task automatic push_frame(input logic [7:0] w0, w1, w2, input int n,
                              input bit with_crc, input logic [7:0] crc);
        push_byte(8'hD5, 1'b0);
        if (n > 0) push_byte(w0, 1'b0);
        if (n > 1) push_byte(w1, 1'b0);
        if (n > 2) push_byte(w2, 1'b0);
        if (with_crc && CRC_BITS > 0) push_byte(crc, 1'b1);
    endtask

    function automatic logic [7:0] crc8_model(input logic [7:0] w0, w1, w2, input int n);
        logic [7:0] c;
        logic [7:0] w;
        logic fb;
        c = 8'h00;
        for (int j = 0; j < n; j++) begin
            w = (j == 0) ? w0 : (j == 1) ? w1 : w2;
            for (int i = 0; i < 8; i++) begin
                fb = c[7] ^ w[i];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    // Scoreboard monitor: every tx_en clock consumes one expected bit; idle line must be 0
    always @(negedge clk) begin
        if (!reset) begin
            if (s_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_extra_bit: tx_en high with nothing expected (t=%0t)", $time);
                end else begin
                    check("tx_bit", int'(s_tx), int'(exp_q.pop_front()));
                end
            end else begin
                check("tx_idle", int'(s_tx), 0);
            end
        end
    end

    // Word source: advance after each accepted handshake
    always @(negedge clk) begin
        if (!reset && s_ready && din_valid) begin
            @(posedge clk);
            #1;
            if (feed_q.size() > 0) feed_q.delete(0);
            refresh_din();
        end
    end

    int r_en, r_done, r_done_at, r_err, r_err_at, r_free_at;
    int r_rdy[$];

    task automatic run_frame(input logic [LEN_W-1:0] len);
        r_en = 0; r_done = 0; r_done_at = -1; r_err = 0; r_err_at = -1; r_free_at = -1;
        r_rdy.delete();
        @(negedge clk);
        tr_start = 1'b1;
        tr_len   = len;
        @(posedge clk);
        #1 tr_start = 1'b0;
        for (int n = 1; n <= 2000; n++) begin
            @(negedge clk);
            if (s_en)    r_en++;
            if (s_ready) r_rdy.push_back(n);
            if (s_done) begin r_done++; r_done_at = n; end
            if (s_err)  begin r_err++;  r_err_at  = n; end
            if (s_free) begin r_free_at = n; break; end
        end
        check("frame_completes", int'(r_free_at > 0), 1);
    endtask

    task automatic bad_len(input logic [LEN_W-1:0] len);
        @(negedge clk);
        tr_start = 1'b1;
        tr_len   = len;
        @(posedge clk);
        #1 tr_start = 1'b0;
        @(negedge clk);
        check("badlen_err", int'(s_err), 1);
        check("badlen_free", int'(s_free), 1);
        check("badlen_tx_en", int'(s_en), 0);
        @(negedge clk);
        check("badlen_err_1cyc", int'(s_err), 0);
        check("badlen_free2", int'(s_free), 1);
    endtask

    initial begin
        reset = 1'b1; tr_start = 1'b0; tr_len = '0; sel = 1'b0;
        din = 8'h00; din_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", int'(d1_tx), 0);
        check("rst_tx_en", int'(d1_en), 0);
        check("rst_free", int'(d1_free), 1);
        check("rst_done", int'(d1_done), 0);
        check("rst_err", int'(d1_err), 0);
        check("rst_ready", int'(d1_ready), 0);
        check("rst_free4", int'(d4_free), 1);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic frame, 1 clock per bit, one word 0xA5
        sel = 1'b0; cpb = 1;
        feed_q.push_back(8'hA5); refresh_din();
        push_frame(8'hA5, 8'h00, 8'h00, 1, 1'b1, 8'h72);
        run_frame(5'd1);
        check("basic_tx_en_clks", r_en, 16 + CRC_BITS);
        check("basic_done_at", r_done_at, 17 + CRC_BITS);
        check("basic_done_cnt", r_done, 1);
        check("basic_err_cnt", r_err, 0);
        check("basic_gap", r_free_at - r_done_at, 4);
        check("basic_ready_cnt", r_rdy.size(), 1);
        if (r_rdy.size() > 0) check("basic_ready_at", r_rdy[0], 8);
        check("basic_sb_empty", exp_q.size(), 0);

        // Three words at 4 clocks per bit
        sel = 1'b1; cpb = 4;
        repeat (2) @(negedge clk);
        feed_q.push_back(8'h01); feed_q.push_back(8'h80); feed_q.push_back(8'hFF); refresh_din();
        push_frame(8'h01, 8'h80, 8'hFF, 3, 1'b1, crc8_model(8'h01, 8'h80, 8'hFF, 3));
        run_frame(5'd3);
        check("multi_tx_en_clks", r_en, 128 + 4 * CRC_BITS);
        check("multi_ready_cnt", r_rdy.size(), 3);
        if (r_rdy.size() == 3) begin
            check("multi_ready0", r_rdy[0], 32);
            check("multi_ready_gap1", r_rdy[1] - r_rdy[0], 32);
            check("multi_ready_gap2", r_rdy[2] - r_rdy[1], 32);
        end
        check("multi_done_cnt", r_done, 1);
        check("multi_gap", r_free_at - r_done_at, 16);
        check("multi_sb_empty", exp_q.size(), 0);

        // Underrun: two words requested, one supplied
        sel = 1'b0; cpb = 1;
        repeat (2) @(negedge clk);
        feed_q.push_back(8'h3C); refresh_din();
        push_frame(8'h3C, 8'h00, 8'h00, 1, 1'b0, 8'h00);
        run_frame(5'd2);
        check("under_tx_en_clks", r_en, 16);
        check("under_err_cnt", r_err, 1);
        check("under_err_at", r_err_at, 17);
        check("under_done_cnt", r_done, 0);
        check("under_gap", r_free_at - r_err_at, 4);
        check("under_sb_empty", exp_q.size(), 0);

        // Out-of-range lengths are rejected in IDLE
        bad_len(5'd0);
        bad_len(5'd17);

        // Asynchronous reset in the middle of the payload
        feed_q.push_back(8'h5A); feed_q.push_back(8'hC3); refresh_din();
        push_frame(8'h5A, 8'hC3, 8'h00, 2, 1'b0, 8'h00);
        @(negedge clk);
        tr_start = 1'b1; tr_len = 5'd2;
        @(posedge clk);
        #1 tr_start = 1'b0;
        repeat (11) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_tx", int'(d1_tx), 0);
        check("arst_tx_en", int'(d1_en), 0);
        check("arst_free", int'(d1_free), 1);
        check("arst_done", int'(d1_done), 0);
        check("arst_err", int'(d1_err), 0);
        check("arst_ready", int'(d1_ready), 0);
        exp_q.delete(); feed_q.delete(); refresh_din();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        feed_q.push_back(8'hA5); refresh_din();
        push_frame(8'hA5, 8'h00, 8'h00, 1, 1'b1, 8'h72);
        run_frame(5'd1);
        check("post_rst_tx_en_clks", r_en, 16 + CRC_BITS);
        check("post_rst_done_cnt", r_done, 1);
        check("post_rst_err_cnt", r_err, 0);
        check("post_rst_sb_empty", exp_q.size(), 0);

`ifdef TX_CRC8_EN
        // CRC trailer with hand-computed value 0x72 for payload 0xA5
        feed_q.push_back(8'hA5); refresh_din();
        push_byte(8'hD5, 1'b0);
        push_byte(8'hA5, 1'b0);
        push_byte(8'h72, 1'b1);
        run_frame(5'd1);
        check("crc_tx_en_clks", r_en, 24);
        check("crc_done_cnt", r_done, 1);
        check("crc_sb_empty", exp_q.size(), 0);
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
